// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID identity checker.
package sysid_check_pkg;

  // Top-level sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_CHECK = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // Result codes reported on fail_code.
  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_ID      = 2'd1;
  localparam logic [1:0] FAIL_TS      = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

  // Word addresses inside the system-ID slave.
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Stall counter width.
  localparam int TMO_W = 16;

  // Retry counter width: enough for 0..max_retries, never narrower than 1 bit.
  function automatic int retry_width(input int max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/sysid_check_timeout.sv
// Stall counter for one read attempt: cleared when a read state is entered,
// advanced on every stalled cycle, and flags expiry once LIMIT stalls are seen.
module sysid_check_timeout
  import sysid_check_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] count;

  // Expiry is a plain compare so it is valid in the same cycle the last stall lands.
  assign expired = (count >= TMO_W'(LIMIT));

  // Count stalled cycles; stop at the limit so the value never wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                count <= '0;
    else if (clear)              count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end

endmodule

// File: rtl/sysid_check_master.sv
// One-shot Avalon-MM read master that reads the system-ID slave (ID word and
// build timestamp), compares both against build-time constants and reports
// a sticky pass/fail result together with the captured words.
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h56E4_BA3A,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          MAX_RETRIES        = 2,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  localparam int RW = retry_width(MAX_RETRIES);

  state_e          state, state_nxt;
  logic            auto_pend;
  logic [RW-1:0]   retry_cnt;
  logic            in_read, accept, stall, expired;
  logic            launch, cap_id, cap_ts, do_check, retry, abort, tmo_clear;

  // Bus strobes are decoded from state; the read is withdrawn once the stall
  // budget is spent so the slave sees a clean gap before any retry.
  assign in_read     = (state == ST_RD_ID) || (state == ST_RD_TS);
  assign avm_read    = in_read && !expired;
  assign avm_address = (state == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy        = in_read || (state == ST_CHECK);
  assign accept      = avm_read && !avm_waitrequest;
  assign stall       = avm_read && avm_waitrequest;

  sysid_check_timeout #(
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmo_clear),
    .enable  (stall),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and one-cycle datapath strobes.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    do_check  = 1'b0;
    retry     = 1'b0;
    abort     = 1'b0;
    tmo_clear = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start || auto_pend) begin
          launch    = 1'b1;
          tmo_clear = 1'b1;
          state_nxt = ST_RD_ID;
        end
      end
      ST_RD_ID, ST_RD_TS: begin
        // An accept can only happen while avm_read is up, i.e. before expiry,
        // so a completed transfer always takes priority over the timeout.
        if (accept) begin
          if (state == ST_RD_ID) begin
            cap_id    = 1'b1;
            tmo_clear = 1'b1;
            state_nxt = ST_RD_TS;
          end else begin
            cap_ts    = 1'b1;
            state_nxt = ST_CHECK;
          end
        end else if (expired) begin
          if (retry_cnt < RW'(MAX_RETRIES)) begin
            retry     = 1'b1;
            tmo_clear = 1'b1;
            state_nxt = ST_RD_ID;
          end else begin
            abort     = 1'b1;
            state_nxt = ST_FIN;
          end
        end
      end
      ST_CHECK: begin
        do_check  = 1'b1;
        state_nxt = ST_FIN;
      end
      ST_FIN: begin
        // busy is already low here, so a start is honoured immediately.
        if (start) begin
          launch    = 1'b1;
          tmo_clear = 1'b1;
          state_nxt = ST_RD_ID;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result, capture and retry bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      auto_pend       <= AUTO_START;
      retry_cnt       <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_code       <= FAIL_NONE;
      id_value        <= '0;
      timestamp_value <= '0;
    end else begin
      if (launch) begin
        auto_pend <= 1'b0;
        retry_cnt <= '0;
        done      <= 1'b0;
        pass      <= 1'b0;
        fail_code <= FAIL_NONE;
      end
      if (retry)  retry_cnt       <= retry_cnt + 1'b1;
      if (cap_id) id_value        <= avm_readdata;
      if (cap_ts) timestamp_value <= avm_readdata;
      if (do_check) begin
        done <= 1'b1;
        if (id_value != EXPECTED_ID) begin
          fail_code <= FAIL_ID;
        end else if (timestamp_value != EXPECTED_TIMESTAMP) begin
          fail_code <= FAIL_TS;
        end else begin
          pass      <= 1'b1;
          fail_code <= FAIL_NONE;
        end
      end
      if (abort) begin
        done      <= 1'b1;
        pass      <= 1'b0;
        fail_code <= FAIL_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Self-checking bench for sysid_check_master: stalling slave model, vector
// table, hand-written stall/reset sequences and randomized runs vs. a model.
module tb_sysid_check_master;

  localparam int          T   = 4;
  localparam int          R   = 2;
  localparam logic [31:0] EID = 32'h0000_0000;
  localparam logic [31:0] ETS = 32'h56E4_BA3A;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [31:0] id_value, timestamp_value;

  // Slave contents and per-word stall length (-1 = stall forever).
  logic [31:0] id_w = EID;
  logic [31:0] ts_w = ETS;
  int          sid = 0;
  int          sts = 0;
  int          scnt = 0;
  int          rd_attempts = 0;
  logic        prev_rd = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_id = '0;
  logic [31:0] exp_ts = '0;

  typedef struct {
    logic [31:0] idw;
    logic [31:0] tsw;
    int          si;
    int          st;
    bit          p;
    logic [1:0]  f;
    int          lat;
    int          att;
  } vec_t;
  vec_t tbl [9];

  always #5 clock = ~clock;

  sysid_check_master #(
    .EXPECTED_ID        (EID),
    .EXPECTED_TIMESTAMP (ETS),
    .TIMEOUT_CYCLES     (T),
    .MAX_RETRIES        (R),
    .AUTO_START         (1'b1)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_code       (fail_code),
    .id_value        (id_value),
    .timestamp_value (timestamp_value)
  );

  // Slave: zero-latency data, stall the addressed word for its programmed count.
  int cur_stall;
  assign cur_stall       = avm_address ? sts : sid;
  assign avm_waitrequest = avm_read && ((cur_stall < 0) || (scnt < cur_stall));
  assign avm_readdata    = avm_address ? ts_w : id_w;

  // Track consecutive stalls and count the starts of each word-0 read attempt.
  always @(posedge clock) begin
    scnt    <= (avm_read && avm_waitrequest) ? scnt + 1 : 0;
    prev_rd <= avm_read;
    if (avm_read && !prev_rd && (avm_address == 1'b0)) rd_attempts <= rd_attempts + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: outcome of one check from stall lengths and word values.
  task automatic model(input logic [31:0] idw, input logic [31:0] tsw, input int si,
                       input int st, output bit p, output logic [1:0] f,
                       output int lat, output int att);
    bit id_ok, ts_ok;
    id_ok = (si >= 0) && (si < T);
    ts_ok = (st >= 0) && (st < T);
    if (id_ok) exp_id = idw;
    if (id_ok && ts_ok) begin
      exp_ts = tsw;
      att    = 1;
      lat    = si + st + 4;
      f      = (idw != EID) ? 2'd1 : (tsw != ETS) ? 2'd2 : 2'd0;
      p      = (f == 2'd0);
    end else begin
      att = R + 1;
      lat = (id_ok ? (si + 1 + T + 1) : (T + 1)) * (R + 1) + 1;
      f   = 2'd3;
      p   = 1'b0;
    end
  endtask

  // Launch a check (or ride an auto-start) and count cycles until done.
  task automatic run(input logic [31:0] idw, input logic [31:0] tsw, input int si,
                     input int st, input bit do_start, output int lat, output int att);
    int base;
    id_w = idw; ts_w = tsw; sid = si; sts = st;
    base = rd_attempts;
    if (do_start) start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    att = rd_attempts - base;
  endtask

  task automatic check_run(input string tag, input bit p, input logic [1:0] f,
                           input int lat_exp, input int att_exp, input int lat, input int att);
    chk({tag, "_latency"}, lat, lat_exp);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_pass"}, pass, p);
    chk({tag, "_fail_code"}, fail_code, f);
    chk({tag, "_attempts"}, att, att_exp);
    chk({tag, "_id_value"}, id_value, exp_id);
    chk({tag, "_ts_value"}, timestamp_value, exp_ts);
    chk({tag, "_read_idle"}, avm_read, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    @(negedge clock);
    chk({tag, "_done_sticky"}, done, 1'b1);
    chk({tag, "_code_sticky"}, fail_code, f);
  endtask

  initial begin
    int lat, att, mlat, matt;
    bit mp;
    logic [1:0] mf;

    tbl[0] = '{EID,   ETS,         0,  0, 1'b1, 2'd0, 4,  1};
    tbl[1] = '{32'h1, ETS,         0,  0, 1'b0, 2'd1, 4,  1};
    tbl[2] = '{EID,   ETS + 32'h1, 0,  0, 1'b0, 2'd2, 4,  1};
    tbl[3] = '{EID,   ETS,         0,  3, 1'b1, 2'd0, 7,  1};
    tbl[4] = '{EID,   ETS,        -1,  0, 1'b0, 2'd3, 16, 3};
    tbl[5] = '{EID,   ETS,         0, -1, 1'b0, 2'd3, 19, 3};
    tbl[6] = '{EID,   ETS,         3,  3, 1'b1, 2'd0, 10, 1};
    tbl[7] = '{EID,   ETS,         4,  0, 1'b0, 2'd3, 16, 3};
    tbl[8] = '{32'h1, 32'h5,       1,  2, 1'b0, 2'd1, 7,  1};

    // Reset values while reset is held.
    #12;
    chk("rst_read", avm_read, 1'b0);
    chk("rst_addr", avm_address, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_fail", fail_code, 2'd0);
    chk("rst_id", id_value, 32'h0);
    chk("rst_ts", timestamp_value, 32'h0);

    // Auto-start after reset release: done on the 4th cycle.
    @(negedge clock);
    reset_n = 1'b1;
    run(EID, ETS, 0, 0, 1'b0, lat, att);
    exp_id = EID; exp_ts = ETS;
    check_run("auto", 1'b1, 2'd0, 4, 1, lat, att);

    // Vector table.
    foreach (tbl[i]) begin
      run(tbl[i].idw, tbl[i].tsw, tbl[i].si, tbl[i].st, 1'b1, lat, att);
      model(tbl[i].idw, tbl[i].tsw, tbl[i].si, tbl[i].st, mp, mf, mlat, matt);
      check_run($sformatf("vec%0d", i), tbl[i].p, tbl[i].f, tbl[i].lat, tbl[i].att, lat, att);
    end

    // Stalled timestamp read: strobe and address stay put across the stall.
    id_w = EID; ts_w = ETS; sid = 0; sts = 3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clock);
      chk($sformatf("stall_rd_c%0d", c), avm_read, 1'b1);
      chk($sformatf("stall_addr_c%0d", c), avm_address, 1'b1);
    end
    @(negedge clock);
    chk("stall_done_c6", done, 1'b0);
    @(negedge clock);
    chk("stall_done_c7", done, 1'b1);
    chk("stall_pass_c7", pass, 1'b1);
    @(negedge clock);

    // Start while busy is ignored; reset mid-RD_TS clears asynchronously.
    id_w = 32'hABCD_0001; ts_w = ETS; sid = 0; sts = -1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_start_addr", avm_address, 1'b1);
    chk("busy_start_read", avm_read, 1'b1);
    chk("busy_start_busy", busy, 1'b1);
    chk("busy_start_id", id_value, 32'hABCD_0001);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_read", avm_read, 1'b0);
    chk("async_rst_addr", avm_address, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_id", id_value, 32'h0);
    exp_id = '0; exp_ts = '0;
    @(negedge clock);
    reset_n = 1'b1;
    run(EID, ETS, 0, 0, 1'b0, lat, att);
    exp_id = EID; exp_ts = ETS;
    check_run("rearm", 1'b1, 2'd0, 4, 1, lat, att);

    // Randomized runs against the reference model.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] ri, rt;
      int rsi, rst;
      ri  = ($urandom_range(0, 3) == 0) ? $urandom : EID;
      rt  = ($urandom_range(0, 3) == 0) ? $urandom : ETS;
      rsi = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      rst = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      model(ri, rt, rsi, rst, mp, mf, mlat, matt);
      run(ri, rt, rsi, rst, 1'b1, lat, att);
      check_run($sformatf("rnd%0d", n), mp, mf, mlat, matt, lat, att);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
